// File: rtl/add_tree_pkg.sv
// Shared definitions for the adder-tree sequencer: state encoding, fx16 clamp limits
// and the tree latency helper.
package add_tree_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } seq_state_t;

  localparam logic [15:0] FX16_MAX = 16'h7FFF;
  localparam logic [15:0] FX16_MIN = 16'h8000;

  // Two register stages per tree level.
  function automatic int tree_lat(input int n);
    return 2 * $clog2(n);
  endfunction

endpackage

// File: rtl/fx16_acc.sv
// 16-bit two's-complement accumulator with synchronous clear and enable.
// Define ADD_TREE_SEQ_SAT_EN to saturate on signed overflow instead of wrapping.
module fx16_acc
  import add_tree_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] add_val,
  output logic [15:0] acc
);

  logic [15:0] acc_reg;
  logic [15:0] acc_next;
  logic [15:0] raw_sum;

  assign raw_sum = acc_reg + add_val;

`ifdef ADD_TREE_SEQ_SAT_EN
  // Overflow only when both operands share a sign that the result lost.
  always_comb begin
    acc_next = raw_sum;
    if (!acc_reg[15] && !add_val[15] && raw_sum[15]) begin
      acc_next = FX16_MAX;
    end else if (acc_reg[15] && add_val[15] && !raw_sum[15]) begin
      acc_next = FX16_MIN;
    end
  end
`else
  assign acc_next = raw_sum;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_reg <= '0;
    end else if (clr) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= acc_next;
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/add_tree_seq.sv
// Sequencer that streams NUM_CHUNKS x N lanes through the adder tree and accumulates
// the per-chunk sums into one result. ADD_TREE_SEQ_SAT_EN selects a saturating accumulator.
module add_tree_seq
  import add_tree_pkg::*;
#(
  parameter int N        = 8,
  parameter int CNT_W    = 8,
  parameter int TREE_LAT = tree_lat(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [CNT_W-1:0]  cfg_num_chunks,
  output logic              busy,
  input  logic              chunk_valid,
  output logic              chunk_ready,
  input  logic [N*16-1:0]   chunk_data,
  output logic              tree_en,
  output logic              tree_valid_in,
  output logic [N*16-1:0]   tree_data,
  input  logic [15:0]       tree_sum,
  input  logic              tree_valid_out,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [15:0]       sum_out
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (N < 2 || (N & (N - 1)) != 0 || TREE_LAT < 1) begin : g_bad_cfg
    $error("add_tree_seq: N must be a power of two >= 2");
  end

  seq_state_t       state_reg;
  logic [CNT_W-1:0] job_len_reg;
  logic [CNT_W-1:0] issued_cnt_reg;
  logic [CNT_W-1:0] recv_cnt_reg;
  logic             busy_reg;
  logic             chunk_ready_reg;
  logic             tree_en_reg;
  logic             sum_valid_reg;

  logic             accept;
  logic             last_accept;
  logic             acc_en;
  logic             acc_clr;
  logic             last_recv;
  logic [15:0]      acc_val;

  assign accept      = chunk_valid && chunk_ready_reg;
  assign last_accept = accept && ((issued_cnt_reg + CNT_ONE) == job_len_reg);
  assign acc_en      = tree_valid_out && ((state_reg == FEED) || (state_reg == DRAIN));
  assign last_recv   = acc_en && ((recv_cnt_reg + CNT_ONE) == job_len_reg);
  assign acc_clr     = (state_reg == IDLE) && cfg_start;

  // Chunk goes straight to the tree so it is captured on the accepting edge.
  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_lane
    assign tree_data[gi*16 +: 16] = accept ? chunk_data[gi*16 +: 16] : 16'h0000;
  end

  assign tree_valid_in = accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      job_len_reg     <= '0;
      issued_cnt_reg  <= '0;
      recv_cnt_reg    <= '0;
      busy_reg        <= 1'b0;
      chunk_ready_reg <= 1'b0;
      tree_en_reg     <= 1'b0;
      sum_valid_reg   <= 1'b0;
    end else begin
      if (accept) issued_cnt_reg <= issued_cnt_reg + CNT_ONE;
      if (acc_en) recv_cnt_reg <= recv_cnt_reg + CNT_ONE;
      case (state_reg)
        IDLE: begin
          if (cfg_start) begin
            job_len_reg    <= cfg_num_chunks;
            issued_cnt_reg <= '0;
            recv_cnt_reg   <= '0;
            busy_reg       <= 1'b1;
            if (cfg_num_chunks != '0) begin
              state_reg       <= FEED;
              chunk_ready_reg <= 1'b1;
              tree_en_reg     <= 1'b1;
            end else begin
              state_reg     <= OUT;
              sum_valid_reg <= 1'b1;
            end
          end
        end
        FEED: begin
          if (last_accept) begin
            chunk_ready_reg <= 1'b0;
            state_reg       <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_recv) begin
            tree_en_reg   <= 1'b0;
            sum_valid_reg <= 1'b1;
            state_reg     <= OUT;
          end
        end
        OUT: begin
          if (sum_ready) begin
            sum_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  fx16_acc u_acc (
    .clk     (clk),
    .rst     (rst),
    .clr     (acc_clr),
    .en      (acc_en),
    .add_val (tree_sum),
    .acc     (acc_val)
  );

  assign busy        = busy_reg;
  assign chunk_ready = chunk_ready_reg;
  assign tree_en     = tree_en_reg;
  assign sum_valid   = sum_valid_reg;
  assign sum_out     = acc_val;

endmodule

// File: tb/tb_add_tree_seq.sv
// Directed bench for add_tree_seq with a behavioural N-lane adder tree model
// (TREE_LAT enabled stages, flushed by reset).
module tb_add_tree_seq;

  localparam int N     = 8;
  localparam int CNT_W = 8;
  localparam int LAT   = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_start;
  logic [CNT_W-1:0]  cfg_num_chunks;
  logic              busy;
  logic              chunk_valid;
  logic              chunk_ready;
  logic [N*16-1:0]   chunk_data;
  logic              tree_en;
  logic              tree_valid_in;
  logic [N*16-1:0]   tree_data;
  logic [15:0]       tree_sum;
  logic              tree_valid_out;
  logic              sum_valid;
  logic              sum_ready;
  logic [15:0]       sum_out;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  add_tree_seq #(.N(N), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_start      (cfg_start),
    .cfg_num_chunks (cfg_num_chunks),
    .busy           (busy),
    .chunk_valid    (chunk_valid),
    .chunk_ready    (chunk_ready),
    .chunk_data     (chunk_data),
    .tree_en        (tree_en),
    .tree_valid_in  (tree_valid_in),
    .tree_data      (tree_data),
    .tree_sum       (tree_sum),
    .tree_valid_out (tree_valid_out),
    .sum_valid      (sum_valid),
    .sum_ready      (sum_ready),
    .sum_out        (sum_out)
  );

  function automatic logic [15:0] lane_sum(input logic [N*16-1:0] d);
    logic [15:0] s;
    s = 16'h0000;
    for (int i = 0; i < N; i++) s = s + d[i*16 +: 16];
    return s;
  endfunction

  function automatic logic [N*16-1:0] lanes(input logic [15:0] v);
    logic [N*16-1:0] d;
    for (int i = 0; i < N; i++) d[i*16 +: 16] = v;
    return d;
  endfunction

  // Tree model: advances only when enabled.
  logic [15:0] pipe_sum [LAT];
  logic        pipe_v   [LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < LAT; k++) begin
        pipe_sum[k] <= 16'h0000;
        pipe_v[k]   <= 1'b0;
      end
    end else if (tree_en) begin
      pipe_v[0]   <= tree_valid_in;
      pipe_sum[0] <= lane_sum(tree_data);
      for (int k = 1; k < LAT; k++) begin
        pipe_v[k]   <= pipe_v[k-1];
        pipe_sum[k] <= pipe_sum[k-1];
      end
    end
  end

  assign tree_valid_out = pipe_v[LAT-1];
  assign tree_sum       = pipe_sum[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns cycles stepped until sum_valid, or limit on timeout.
  task automatic wait_sum(input int limit, output int n);
    n = 0;
    while (!sum_valid && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) chk("sum_valid_timeout", 32'(n), 32'(limit - 1));
  endtask

  logic [15:0] exp_sat_case;
  logic [15:0] held_sum;
  int n;
  int k;

  initial begin
    rst            = 1'b0;
    cfg_start      = 1'b0;
    cfg_num_chunks = '0;
    chunk_valid    = 1'b0;
    chunk_data     = '0;
    sum_ready      = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_chunk_ready", 32'(chunk_ready), 32'd0);
    chk("rst_tree_en", 32'(tree_en), 32'd0);
    chk("rst_tree_valid_in", 32'(tree_valid_in), 32'd0);
    chk("rst_sum_valid", 32'(sum_valid), 32'd0);
    chk("rst_sum_out", 32'(sum_out), 32'h0);
    chk("rst_tree_data", 32'(tree_data[31:0]), 32'h0);
    repeat (2) step();
    @(negedge clk);
    rst = 1'b1;
    step();

    // Minimum job: one chunk of 0x0100 lanes.
    cfg_start      = 1'b1;
    cfg_num_chunks = 8'd1;
    chunk_valid    = 1'b1;
    chunk_data     = lanes(16'h0100);
    sum_ready      = 1'b1;
    step();
    cfg_start = 1'b0;
    chk("j1_busy", 32'(busy), 32'd1);
    chk("j1_chunk_ready", 32'(chunk_ready), 32'd1);
    chk("j1_tree_valid_in", 32'(tree_valid_in), 32'd1);
    chk("j1_tree_en", 32'(tree_en), 32'd1);
    step();
    chunk_valid = 1'b0;
    chk("j1_ready_fall", 32'(chunk_ready), 32'd0);
    wait_sum(60, n);
    chk("j1_latency", 32'(n + 2), 32'd8);
    chk("j1_sum", 32'(sum_out), 32'h0800);
    chk("j1_tree_en_out", 32'(tree_en), 32'd0);
    step();
    chk("j1_busy_fall", 32'(busy), 32'd0);
    chk("j1_valid_fall", 32'(sum_valid), 32'd0);

    // Four chunks with bubbles; sum_ready held low to test OUT hold.
    sum_ready      = 1'b0;
    cfg_start      = 1'b1;
    cfg_num_chunks = 8'd4;
    step();
    cfg_start = 1'b0;
    k = 0;
    n = 0;
    while (k < 4 && n < 40) begin
      chunk_valid = n[0];
      chunk_data  = lanes(16'(16'h0010 * (k + 1)));
      #1;
      if (!chunk_valid) chk("j4_bubble", 32'(tree_valid_in), 32'd0);
      if (chunk_valid && chunk_ready) k++;
      step();
      n++;
    end
    chunk_valid = 1'b0;
    chk("j4_accepts", 32'(k), 32'd4);
    chk("j4_ready_fall", 32'(chunk_ready), 32'd0);
    wait_sum(60, n);
    chk("j4_sum", 32'(sum_out), 32'h0500);
    held_sum = sum_out;
    for (int c = 0; c < 10; c++) begin
      cfg_start      = (c == 3);
      cfg_num_chunks = 8'd0;
      step();
      chk("hold_valid", 32'(sum_valid), 32'd1);
      chk("hold_sum", 32'(sum_out), 32'h0500);
    end
    cfg_start = 1'b0;
    sum_ready = 1'b1;
    step();
    chk("hold_release", 32'(sum_valid), 32'd0);
    step();
    chk("hold_idle_busy", 32'(busy), 32'd0);

    // Zero-length job.
    cfg_start      = 1'b1;
    cfg_num_chunks = 8'd0;
    sum_ready      = 1'b0;
    step();
    cfg_start = 1'b0;
    chk("j0_valid", 32'(sum_valid), 32'd1);
    chk("j0_sum", 32'(sum_out), 32'h0);
    chk("j0_chunk_ready", 32'(chunk_ready), 32'd0);
    sum_ready = 1'b1;
    step();
    chk("j0_busy_fall", 32'(busy), 32'd0);

    // Overflow case: each chunk sums to 0x8000.
    cfg_start      = 1'b1;
    cfg_num_chunks = 8'd2;
    chunk_valid    = 1'b1;
    chunk_data     = lanes(16'h1000);
    step();
    cfg_start = 1'b0;
    step();
    step();
    chunk_valid = 1'b0;
    wait_sum(60, n);
`ifdef ADD_TREE_SEQ_SAT_EN
    exp_sat_case = 16'h8000;
`else
    exp_sat_case = 16'h0000;
`endif
    chk("ovf_sum", 32'(sum_out), 32'(exp_sat_case));
    step();

    // Asynchronous reset mid-FEED, then a fresh one-chunk job.
    cfg_start      = 1'b1;
    cfg_num_chunks = 8'd3;
    chunk_valid    = 1'b1;
    chunk_data     = lanes(16'h0100);
    step();
    cfg_start = 1'b0;
    step();
    #3;
    rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_chunk_ready", 32'(chunk_ready), 32'd0);
    chk("arst_tree_en", 32'(tree_en), 32'd0);
    chk("arst_tree_valid_in", 32'(tree_valid_in), 32'd0);
    chunk_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    cfg_start      = 1'b1;
    cfg_num_chunks = 8'd1;
    chunk_valid    = 1'b1;
    chunk_data     = lanes(16'h0001);
    step();
    cfg_start = 1'b0;
    step();
    chunk_valid = 1'b0;
    wait_sum(60, n);
    chk("post_rst_sum", 32'(sum_out), 32'h0008);
    step();
    chk("post_rst_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
